// File: rtl/serial_pkg.sv
// Shared definitions for the single-line serial link.
//   tx_state_t  : transmitter frame states
//   *_LEVEL     : line levels for idle, start and stop, shared with the capture side
//   cnt_width() : width of a counter that must hold 0..n-1 (minimum 1 bit)
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer for the serial transmitter.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   clear   : holds the timer at the first cycle of a bit period
//   bit_end : high on the last cycle of each CLKS_PER_BIT-cycle bit period
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned     TW   = cnt_width(CLKS_PER_BIT);
  localparam logic [TW-1:0]   LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  // With CLKS_PER_BIT=1 the count never leaves 0, so every cycle ends a bit.
  always_comb bit_end = (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_WIDTH data bits LSB first,
// optional even parity, stop bit. All outputs are registered.
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   tx_data  : word to send, sampled on the accept edge only
//   tx_valid : tx_data is valid
//   tx_ready : block can accept a word
//   tx_out   : serial line, idle high
//   tx_done  : one-cycle pulse when a frame completes
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_done
);

  localparam int unsigned   BW       = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_t             state, state_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [BW-1:0]         bit_cnt, bit_cnt_nx;
  logic                  parity, parity_nx;
  logic                  tx_out_nx, tx_ready_nx, tx_done_nx;
  logic                  bit_end;
  logic                  timer_clear;

  // Holding the timer cleared through IDLE guarantees a full first bit
  // period starting the cycle after the accept edge.
  always_comb timer_clear = (state == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      parity   <= 1'b0;
      tx_out   <= IDLE_LEVEL;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bit_cnt  <= bit_cnt_nx;
      parity   <= parity_nx;
      tx_out   <= tx_out_nx;
      tx_ready <= tx_ready_nx;
      tx_done  <= tx_done_nx;
    end
  end

  // Outputs are registered, so each transition also loads the line level
  // of the state being entered.
  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_cnt_nx  = bit_cnt;
    parity_nx   = parity;
    tx_out_nx   = tx_out;
    tx_ready_nx = 1'b0;
    tx_done_nx  = 1'b0;

    case (state)
      IDLE: begin
        tx_out_nx   = IDLE_LEVEL;
        tx_ready_nx = 1'b1;
        if (tx_valid && tx_ready) begin
          shreg_nx    = tx_data;
          parity_nx   = ^tx_data;
          bit_cnt_nx  = '0;
          state_nx    = START;
          tx_out_nx   = START_LEVEL;
          tx_ready_nx = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_nx  = DATA;
          tx_out_nx = shreg[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_nx  = PARITY;
              tx_out_nx = parity;
            end else begin
              state_nx  = STOP;
              tx_out_nx = STOP_LEVEL;
            end
          end else begin
            shreg_nx   = shreg >> 1;
            bit_cnt_nx = bit_cnt + BW'(1);
            tx_out_nx  = shreg_nx[0];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_nx  = STOP;
          tx_out_nx = STOP_LEVEL;
        end
      end

      STOP: begin
        if (bit_end) begin
          state_nx    = IDLE;
          tx_out_nx   = IDLE_LEVEL;
          tx_ready_nx = 1'b1;
          tx_done_nx  = 1'b1;
        end
      end

      default: begin
        state_nx    = IDLE;
        tx_out_nx   = IDLE_LEVEL;
        tx_ready_nx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (defaults, even parity, one cycle per
// bit) checked every cycle against a frame-level model, plus literal frames.
module tb_serial_tx;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_n [3];
  logic       valid [3];
  logic [7:0] data  [3];
  logic       out   [3];
  logic       rdy   [3];
  logic       done  [3];

  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
    .clock(clock), .reset_n(rst_n[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(rdy[0]), .tx_out(out[0]), .tx_done(done[0]));
  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
    .clock(clock), .reset_n(rst_n[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(rdy[1]), .tx_out(out[1]), .tx_done(done[1]));
  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
    .clock(clock), .reset_n(rst_n[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(rdy[2]), .tx_out(out[2]), .tx_done(done[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cpb(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int par(input int i);
    return (i == 1) ? 1 : 0;
  endfunction

  // Frame-level model: on acceptance the whole expected line waveform is
  // laid out cycle by cycle; the model then just walks through it.
  bit   m_busy [3];
  int   m_pos  [3];
  int   m_len  [3];
  bit   m_line [3][64];
  bit   m_done [3];
  int   m_acc  [3];
  int   cyc = 0;

  logic cap      [3][64];
  int   done_cnt [3];
  int   lat      [3];

  task automatic build_frame(input int i, input logic [7:0] d);
    bit b[11];
    int nb;
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    nb = 9;
    if (par(i) != 0) begin
      b[9] = ^d;
      nb   = 10;
    end
    b[nb] = 1'b1;
    nb++;
    m_len[i] = nb * cpb(i);
    for (int k = 0; k < nb; k++)
      for (int r = 0; r < cpb(i); r++)
        m_line[i][k*cpb(i)+r] = b[k];
    m_pos[i]  = 0;
    m_busy[i] = 1'b1;
    m_acc[i]  = cyc;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_pos[i] = 0; m_len[i] = 0; m_done[i] = 0;
      m_acc[i] = 0; done_cnt[i] = 0; lat[i] = 0;
    end
    forever begin
      @(posedge clock);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (rst_n[i] !== 1'b1) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b0;
        end else begin
          bit acc;
          acc = (valid[i] === 1'b1) && !m_busy[i];
          m_done[i] = 1'b0;
          if (m_busy[i]) begin
            m_pos[i]++;
            if (m_pos[i] == m_len[i]) begin
              m_busy[i] = 1'b0;
              m_done[i] = 1'b1;
            end
          end
          if (acc) build_frame(i, data[i]);
        end
      end
    end
  end

  // Compare process: every cycle, every instance.
  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        logic e_out, e_rdy, e_done;
        if (rst_n[i] !== 1'b1) begin
          e_out = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
        end else if (m_busy[i]) begin
          e_out = m_line[i][m_pos[i]]; e_rdy = 1'b0; e_done = 1'b0;
        end else begin
          e_out = 1'b1; e_rdy = 1'b1; e_done = m_done[i];
        end
        chk($sformatf("u%0d tx_out", i),   {31'd0, out[i]},  {31'd0, e_out});
        chk($sformatf("u%0d tx_ready", i), {31'd0, rdy[i]},  {31'd0, e_rdy});
        chk($sformatf("u%0d tx_done", i),  {31'd0, done[i]}, {31'd0, e_done});
        if (m_busy[i] && rst_n[i] === 1'b1) cap[i][m_pos[i]] = out[i];
        if (done[i] === 1'b1) begin
          done_cnt[i]++;
          lat[i] = cyc - m_acc[i];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input int i, input logic [7:0] d);
    tick();
    valid[i] = 1'b1;
    data[i]  = d;
    tick();
    valid[i] = 1'b0;
    data[i]  = 8'($urandom);
  endtask

  task automatic wait_done(input int i, input int maxc);
    int s;
    int n;
    s = done_cnt[i];
    n = 0;
    while (done_cnt[i] == s && n < maxc) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk($sformatf("u%0d tx_done within %0d cycles", i, maxc), 32'(done_cnt[i] - s), 32'd1);
  endtask

  // bits[k] is the k-th bit on the line (start bit at index 0).
  task automatic check_frame(input int i, input logic [10:0] bits, input int nb, input string name);
    for (int b = 0; b < nb; b++)
      chk($sformatf("%s bit%0d", name, b), {31'd0, cap[i][b*cpb(i)]}, {31'd0, bits[b]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int dcyc;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; valid[i] = 1'b0; data[i] = 8'h00;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d reset tx_out", i),   {31'd0, out[i]},  32'd1);
      chk($sformatf("u%0d reset tx_ready", i), {31'd0, rdy[i]},  32'd1);
      chk($sformatf("u%0d reset tx_done", i),  {31'd0, done[i]}, 32'd0);
    end

    // Asynchronous reset during the start bit of u1.
    send(1, 8'h00);
    tick();
    chk("u1 start bit low", {31'd0, out[1]}, 32'd0);
    rst_n[1] = 1'b0;
    #1;
    chk("u1 async reset tx_out", {31'd0, out[1]}, 32'd1);
    chk("u1 async reset tx_ready", {31'd0, rdy[1]}, 32'd1);
    tick();
    rst_n[1] = 1'b1;

    // Single frame, defaults.
    send(0, 8'hA5);
    wait_done(0, 100);
    check_frame(0, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, "u0 A5");
    chk("u0 A5 latency", 32'(lat[0]), 32'd40);

    // Even parity.
    send(1, 8'h07);
    wait_done(1, 100);
    check_frame(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11, "u1 07");
    chk("u1 07 latency", 32'(lat[1]), 32'd44);
    send(1, 8'hA5);
    wait_done(1, 100);
    check_frame(1, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, "u1 A5");

    // Back-to-back with tx_valid held high.
    tick();
    valid[0] = 1'b1;
    data[0]  = 8'h01;
    tick();
    data[0]  = 8'h80;
    wait_done(0, 100);
    dcyc = cyc;
    check_frame(0, {1'b0, 1'b1, 8'h01, 1'b0}, 10, "u0 01");
    chk("u0 idle cycle in done", {31'd0, out[0]}, 32'd1);
    tick();
    valid[0] = 1'b0;
    @(negedge clock); #1;
    chk("u0 second start bit", {31'd0, out[0]}, 32'd0);
    chk("u0 start follows done", 32'(cyc - dcyc), 32'd1);
    wait_done(0, 100);
    check_frame(0, {1'b0, 1'b1, 8'h80, 1'b0}, 10, "u0 80");

    // tx_valid while busy is ignored.
    send(0, 8'h00);
    repeat (12) tick();
    valid[0] = 1'b1;
    data[0]  = 8'hFF;
    tick();
    valid[0] = 1'b0;
    wait_done(0, 100);
    check_frame(0, {1'b0, 1'b1, 8'h00, 1'b0}, 10, "u0 00");
    s = done_cnt[0];
    repeat (50) tick();
    chk("u0 no frame after ignored valid", 32'(done_cnt[0] - s), 32'd0);

    // Reset mid-frame, one cycle per bit.
    send(2, 8'h55);
    tick();
    tick();
    rst_n[2] = 1'b0;
    #1;
    chk("u2 mid-frame reset tx_out", {31'd0, out[2]}, 32'd1);
    chk("u2 mid-frame reset tx_done", {31'd0, done[2]}, 32'd0);
    s = done_cnt[2];
    tick();
    rst_n[2] = 1'b1;
    repeat (20) tick();
    chk("u2 no done after abandon", 32'(done_cnt[2] - s), 32'd0);
    send(2, 8'h55);
    wait_done(2, 50);
    check_frame(2, {1'b0, 1'b1, 8'h55, 1'b0}, 10, "u2 55");
    chk("u2 55 latency", 32'(lat[2]), 32'd10);

    // Randomized traffic on all instances, occasional resets on u2.
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        valid[i] = ($urandom_range(0, 2) == 0);
        data[i]  = 8'($urandom);
      end
      rst_n[2] = ($urandom_range(0, 399) != 0);
    end
    tick();
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    rst_n[2] = 1'b1;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
